// File: rtl/fp_add_tree_acc.sv
// fp_add_tree_acc: per-beat floating-point adder tree feeding one feedback accumulator
// that keeps up to ADD_LATENCY partial sums interleaved, then folds them on drain.
module fp_add_tree_acc #(
    parameter int unsigned EXP         = 8,
    parameter int unsigned MANT        = 7,
    parameter int unsigned WIDTH       = 1 + EXP + MANT,
    parameter int unsigned ITEMS       = 27,
    parameter int unsigned ADD_LATENCY = 3
) (
    input  logic                   clock,
    input  logic                   clock_areset_n,
    input  logic                   data_valid,
    input  logic                   data_last,
    input  logic [ITEMS*WIDTH-1:0] data,
    output logic                   data_ready,
    output logic                   result_valid,
    output logic [WIDTH-1:0]       result
);
    // ADD_LATENCY must be >= 1: the accumulator feedback relies on it being registered
    localparam int unsigned L    = ADD_LATENCY;
    localparam int unsigned D    = $clog2(ITEMS);
    localparam int unsigned P    = 1 << D;
    localparam int unsigned TL   = D * L;
    localparam int unsigned SW   = MANT + 1;
    localparam int unsigned EMAX = (1 << EXP) - 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic             tree_valid;
    logic             tree_last;
    logic [WIDTH-1:0] node [1:2*P-1];

    logic [WIDTH-1:0] acc_a, acc_b;
    logic             acc_in_valid;
    logic [WIDTH-1:0] apipe_d [L];
    logic [WIDTH-1:0] apipe_q [L];
    logic [L-1:0]     avalid_d, avalid_q;
    logic [WIDTH-1:0] fb;
    logic             fb_valid;
    logic             acc_busy;

    logic [WIDTH-1:0] h_d, h_q;
    logic             h_full_d, h_full_q;
    logic             data_ready_d, data_ready_q;
    logic             result_valid_d, result_valid_q;
    logic [WIDTH-1:0] result_d, result_q;

    // Truncating adder: exponent 0 means zero (exact identity), exponent overflow saturates
    function automatic logic [WIDTH-1:0] fp_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] big;
        logic [WIDTH-1:0] sml;
        logic [SW-1:0]    m_big;
        logic [SW-1:0]    m_sml;
        logic [SW:0]      sum;
        logic [MANT-1:0]  nrm;
        logic [EXP-1:0]   e_big;
        logic [EXP-1:0]   e_diff;
        logic             found;
        int unsigned      lz;
        int unsigned      e_res;
        logic [WIDTH-1:0] r;
        r     = '0;
        big   = x;
        sml   = y;
        if (y[WIDTH-2:0] > x[WIDTH-2:0]) begin
            big = y;
            sml = x;
        end
        e_big  = big[WIDTH-2 -: EXP];
        e_diff = e_big - sml[WIDTH-2 -: EXP];
        m_big  = {1'b1, big[MANT-1:0]};
        m_sml  = {1'b1, sml[MANT-1:0]} >> e_diff;
        sum    = '0;
        nrm    = '0;
        lz     = 0;
        e_res  = 0;
        found  = 1'b0;
        if (x[WIDTH-2 -: EXP] == '0) begin
            r = (y[WIDTH-2 -: EXP] == '0) ? '0 : y;
        end else if (y[WIDTH-2 -: EXP] == '0) begin
            r = x;
        end else if (big[WIDTH-1] == sml[WIDTH-1]) begin
            sum = {1'b0, m_big} + {1'b0, m_sml};
            if (sum[SW]) begin
                e_res = 32'(e_big) + 1;
                nrm   = sum[SW-1:1];
            end else begin
                e_res = 32'(e_big);
                nrm   = sum[MANT-1:0];
            end
            if (e_res >= EMAX) r = {big[WIDTH-1], EXP'(EMAX - 1), {MANT{1'b1}}};
            else               r = {big[WIDTH-1], EXP'(e_res), nrm};
        end else begin
            sum = {1'b0, m_big} - {1'b0, m_sml};
            for (int i = SW - 1; i >= 0; i--) begin
                if (!found) begin
                    if (sum[i]) found = 1'b1;
                    else        lz = lz + 1;
                end
            end
            nrm = MANT'(sum[SW-1:0] << lz);
            if (found && (32'(e_big) > lz)) r = {big[WIDTH-1], EXP'(32'(e_big) - lz), nrm};
        end
        return r;
    endfunction

    assign accept = data_valid & data_ready_q;

    genvar gi;
    generate
        // Leaves: real lanes, then all-zero padding up to a power of two
        for (gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < ITEMS) begin : g_lane
                assign node[P+gi] = data[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign node[P+gi] = '0;
            end
        end

        // Heap-ordered tree: node n = add(node 2n, node 2n+1), each add L cycles deep
        for (gi = 1; gi < P; gi++) begin : g_node
            logic [WIDTH-1:0] pipe_d [L];
            logic [WIDTH-1:0] pipe_q [L];
            // fresh sum enters the head, older sums shift toward the output
            always_comb begin
                pipe_d[0] = fp_add(node[2*gi], node[2*gi+1]);
                for (int unsigned k = 1; k < L; k++) pipe_d[k] = pipe_q[k-1];
            end
            // datapath pipeline, qualified by tags so it needs no reset
            always_ff @(posedge clock) pipe_q <= pipe_d;
            assign node[gi] = pipe_q[L-1];
        end

        if (TL > 0) begin : g_tag
            logic [TL-1:0] tv_d, tv_q, tl_d, tl_q;
            // valid and last tags travel alongside each beat through the tree
            always_comb begin
                tv_d = TL'({tv_q, accept});
                tl_d = TL'({tl_q, accept & data_last});
            end
            // tag shift registers
            always_ff @(posedge clock or negedge clock_areset_n) begin
                if (!clock_areset_n) begin
                    tv_q <= '0;
                    tl_q <= '0;
                end else begin
                    tv_q <= tv_d;
                    tl_q <= tl_d;
                end
            end
            assign tree_valid = tv_q[TL-1];
            assign tree_last  = tl_q[TL-1];
        end else begin : g_notag
            assign tree_valid = accept;
            assign tree_last  = accept & data_last;
        end
    endgenerate

    // accumulator pipeline next values; its output loops back to operand b
    always_comb begin
        apipe_d[0] = fp_add(acc_a, acc_b);
        for (int unsigned k = 1; k < L; k++) apipe_d[k] = apipe_q[k-1];
        avalid_d = L'({avalid_q, acc_in_valid});
    end

    assign fb       = apipe_q[L-1];
    assign fb_valid = avalid_q[L-1];
    assign acc_busy = |avalid_q;

    // state register
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) state_q <= S_IDLE;
        else                 state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept && data_last) state_d = (tree_valid && tree_last) ? S_DRAIN : S_FLUSH;
                else if (accept)         state_d = S_ACCUM;
            end
            S_FLUSH: if (tree_valid && tree_last) state_d = S_DRAIN;
            S_DRAIN: if (h_full_q && !acc_busy)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs and accumulator steering; drain pairs partials through hold register H
    always_comb begin
        acc_a          = tree_valid ? node[1] : '0;
        acc_b          = fb_valid ? fb : '0;
        acc_in_valid   = tree_valid | fb_valid;
        h_d            = h_q;
        h_full_d       = h_full_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        data_ready_d   = (state_d == S_IDLE) || (state_d == S_ACCUM);
        if (state_q == S_DRAIN) begin
            acc_a        = '0;
            acc_b        = '0;
            acc_in_valid = 1'b0;
            if (fb_valid) begin
                if (h_full_q) begin
                    acc_a        = h_q;
                    acc_b        = fb;
                    acc_in_valid = 1'b1;
                    h_full_d     = 1'b0;
                end else begin
                    h_d      = fb;
                    h_full_d = 1'b1;
                end
            end else if (h_full_q && !acc_busy) begin
                result_d       = h_q;
                result_valid_d = 1'b1;
                h_full_d       = 1'b0;
            end
        end
    end

    // control, tag and output flops
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            avalid_q       <= '0;
            h_full_q       <= 1'b0;
            data_ready_q   <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            avalid_q       <= avalid_d;
            h_full_q       <= h_full_d;
            data_ready_q   <= data_ready_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
        end
    end

    // accumulator and hold datapath, qualified by tags so no reset
    always_ff @(posedge clock) begin
        apipe_q <= apipe_d;
        h_q     <= h_d;
    end

    assign data_ready   = data_ready_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
endmodule

// File: tb/tb_fp_add_tree_acc.sv
// tb_fp_add_tree_acc: directed checks of fp_add_tree_acc, bfloat16-style format, L=3
`timescale 1ns/1ps
module tb_fp_add_tree_acc;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        v4 = 1'b0, l4 = 1'b0, v3 = 1'b0, l3 = 1'b0;
    logic [63:0] d4 = '0;
    logic [47:0] d3 = '0;
    logic        rdy4, rv4, rdy3, rv3;
    logic [15:0] r4, r3;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0, p4 = 0, p3 = 0, pc4 = 0, pc3 = 0;
    logic [15:0] res4 = '0, res3 = '0;
    int          acc_cyc = 0;

    int          p_before, first_acc, hi_cnt, w;
    int          gaps [7] = '{3, 0, 4, 1, 2, 0, 4};
    logic [63:0] ones = {4{16'h3F80}};

    always #5 clk = ~clk;

    fp_add_tree_acc #(.EXP(8), .MANT(7), .WIDTH(16), .ITEMS(4), .ADD_LATENCY(3)) u_dut4 (
        .clock(clk), .clock_areset_n(rst_n), .data_valid(v4), .data_last(l4), .data(d4),
        .data_ready(rdy4), .result_valid(rv4), .result(r4)
    );

    fp_add_tree_acc #(.EXP(8), .MANT(7), .WIDTH(16), .ITEMS(3), .ADD_LATENCY(3)) u_dut3 (
        .clock(clk), .clock_areset_n(rst_n), .data_valid(v3), .data_last(l3), .data(d3),
        .data_ready(rdy3), .result_valid(rv3), .result(r3)
    );

    // pulse monitor sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rv4 === 1'b1) begin p4++; res4 = r4; pc4 = cyc; end
        if (rv3 === 1'b1) begin p3++; res3 = r3; pc3 = cyc; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // offer one beat from a negedge, return at the negedge after it was accepted
    task automatic send(input int sel, input logic [63:0] d, input logic last);
        int wt;
        wt = 0;
        if (sel == 4) begin v4 = 1'b1; d4 = d; l4 = last; end
        else          begin v3 = 1'b1; d3 = d[47:0]; l3 = last; end
        while ((((sel == 4) ? rdy4 : rdy3) !== 1'b1) && (wt < 50)) begin
            @(negedge clk);
            wt++;
        end
        check("accept_wait", 32'(wt < 50), 32'd1);
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic wait_pulse(input int sel, input int start, input int budget);
        int wt;
        wt = 0;
        while ((((sel == 4) ? p4 : p3) == start) && (wt < budget)) begin
            @(negedge clk);
            wt++;
        end
        check("pulse_wait", 32'(((sel == 4) ? p4 : p3) != start), 32'd1);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready4", 32'(rdy4), 32'd0);
        check("rst_ready3", 32'(rdy3), 32'd0);
        check("rst_rvalid4", 32'(rv4), 32'd0);
        check("rst_result4", 32'(r4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst4", 32'(rdy4), 32'd1);
        check("ready_after_rst3", 32'(rdy3), 32'd1);

        // single beat of four 1.0 lanes
        p_before = p4;
        send(4, ones, 1'b1);
        first_acc = acc_cyc;
        v4 = 1'b0; l4 = 1'b0;
        wait_pulse(4, p_before, 40);
        check("t1_result", 32'(res4), 32'h4080);
        check("t1_latency", 32'((pc4 - first_acc) <= 11), 32'd1);
        repeat (10) @(negedge clk);
        check("t1_pulse_count", 32'(p4 - p_before), 32'd1);

        // three lanes {2.0,1.0,1.0}, fourth lane padded with zero
        p_before = p3;
        w = p4;
        send(3, {16'h0000, 16'h3F80, 16'h3F80, 16'h4000}, 1'b1);
        first_acc = acc_cyc;
        v3 = 1'b0; l3 = 1'b0;
        wait_pulse(3, p_before, 40);
        check("t2_result", 32'(res3), 32'h4080);
        check("t2_latency", 32'((pc3 - first_acc) <= 11), 32'd1);
        repeat (10) @(negedge clk);
        check("t2_pulse_count", 32'(p3 - p_before), 32'd1);
        check("t2_other_quiet", 32'(p4 - w), 32'd0);

        // eight back-to-back beats of 1.0
        p_before = p4;
        for (int i = 0; i < 8; i++) begin
            send(4, ones, 1'(i == 7));
            if (i == 0) first_acc = acc_cyc;
        end
        v4 = 1'b0; l4 = 1'b0;
        hi_cnt = 0;
        w = 0;
        while (p4 == p_before && w < 60) begin
            if (rdy4 !== 1'b0) hi_cnt++;
            @(negedge clk);
            w++;
        end
        check("t3_ready_low", 32'(hi_cnt), 32'd0);
        check("t3_pulse_seen", 32'(p4 - p_before), 32'd1);
        check("t3_result", 32'(res4), 32'h4200);
        check("t3_latency", 32'((pc4 - first_acc) <= 24), 32'd1);
        repeat (10) @(negedge clk);
        check("t3_pulse_count", 32'(p4 - p_before), 32'd1);

        // same eight beats with idle gaps between them
        p_before = p4;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                v4 = 1'b0;
                repeat (gaps[i-1]) @(negedge clk);
            end
            send(4, ones, 1'(i == 7));
        end
        v4 = 1'b0; l4 = 1'b0;
        wait_pulse(4, p_before, 80);
        check("t4_result", 32'(res4), 32'h4200);
        repeat (10) @(negedge clk);
        check("t4_pulse_count", 32'(p4 - p_before), 32'd1);

        // reset in the middle of a burst, then a fresh beat of 0.5 lanes
        p_before = p4;
        for (int i = 0; i < 3; i++) send(4, ones, 1'b0);
        v4 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_ready", 32'(rdy4), 32'd0);
        check("t5_rst_rvalid", 32'(rv4), 32'd0);
        check("t5_rst_result", 32'(r4), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_back", 32'(rdy4), 32'd1);
        repeat (20) @(negedge clk);
        check("t5_no_stale", 32'(p4 - p_before), 32'd0);
        send(4, {4{16'h3F00}}, 1'b1);
        v4 = 1'b0; l4 = 1'b0;
        wait_pulse(4, p_before, 40);
        check("t5_result", 32'(res4), 32'h4000);
        repeat (10) @(negedge clk);
        check("t5_pulse_count", 32'(p4 - p_before), 32'd1);

        // valid held high with 16.0 lanes through flush and drain
        p_before = p4;
        send(4, ones, 1'b1);
        d4 = {4{16'h4180}};
        l4 = 1'b1;
        v4 = 1'b1;
        hi_cnt = 0;
        w = 0;
        while (p4 == p_before && w < 60) begin
            if (rdy4 !== 1'b0) hi_cnt++;
            @(negedge clk);
            w++;
        end
        check("t6_ready_low", 32'(hi_cnt), 32'd0);
        check("t6_first_result", 32'(res4), 32'h4080);
        check("t6_ready_idle", 32'(rdy4), 32'd1);
        @(negedge clk);
        v4 = 1'b0; l4 = 1'b0;
        wait_pulse(4, p_before + 1, 40);
        check("t6_second_result", 32'(res4), 32'h4280);
        repeat (10) @(negedge clk);
        check("t6_pulse_count", 32'(p4 - p_before), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
